emu_sequencer: RTL and testbench
================================

EMU_SEQUENCER -- requirements
Module: emu_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports listed below (clock and reset first).
REQ-002 The module SHALL have the following parameters:
- NUM_STIM, default 2, number of stimulus bytes per frame (1..8).
- NUM_OUT, default 3, number of output bytes per frame (1..8).
- CLK_HIGH, default 1, clk_dut high phase in clk_emu cycles (1..15).
- CLK_LOW, default 1, clk_dut low phase in clk_emu cycles (1..15).
REQ-003 The module SHALL have the following ports:
- clk_emu  in  1  emulation clock; all logic on its rising edge.
- nRST  in  1  asynchronous active-low reset.
- rx_data  in  8  host stimulus byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer accepts rx_data.
- tx_data  out  8  captured output byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts tx_data.
- Din_emu  out  8  stimulus byte to the wrapper.
- Addr_emu  out  3  wrapper array index.
- load_emu  out  1  wrapper stimulus-apply strobe.
- get_emu  out  1  wrapper output-capture strobe.
- Dout_emu  in  8  wrapper output byte; registered, valid one cycle after Addr_emu.
- clk_dut  out  1  generated DUT clock.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  16  count of completed frames.

Function
REQ-004 All outputs SHALL be registered; clk_dut SHALL come straight from a flop, glitch-free.
REQ-005 The state machine SHALL have the states IDLE, STIM, WR, LOAD, CHI, CLO, GET, RADDR, RCAP and SEND.
REQ-006 IDLE/STIM behaviour:
- rx_ready=1 only in IDLE/STIM.
- On each rx handshake: Din_emu<=rx_data, Addr_emu<=idx, idx++; first handshake moves IDLE->STIM.
- Handshake with idx==NUM_STIM-1 -> WR.
- rx_valid low SHALL stall indefinitely.
REQ-007 WR SHALL last 1 cycle with load_emu=get_emu=0 and Din_emu/Addr_emu held, so the wrapper writes the last byte.
REQ-008 LOAD SHALL last 1 cycle with load_emu=1.
REQ-009 CHI SHALL last CLK_HIGH cycles with clk_dut=1; CLO SHALL last CLK_LOW cycles with clk_dut=0.
REQ-010 GET SHALL last 1 cycle with get_emu=1; on entry to GET, the output index k SHALL be set to 0.
REQ-011 Read-out, repeated for k=0..NUM_OUT-1:
- On entry to RADDR: Addr_emu<=k.
- RADDR: 1 cycle.
- RCAP: 1 cycle; at its end tx_data<=Dout_emu and tx_valid<=1.
- SEND: hold tx_data and tx_valid until tx_ready; then k++ and go to RADDR.
- After the last byte: tx_valid<=0, frame_cnt++, go to IDLE.
REQ-012 load_emu, get_emu and clk_dut SHALL be mutually exclusive; none SHALL be high outside its own state.
REQ-013 Addr_emu SHALL never exceed max(NUM_STIM,NUM_OUT)-1.
REQ-014 Stimulus writes made while reading are harmless, because every frame rewrites all NUM_STIM bytes before LOAD.
REQ-015 Latency with defaults: tx_valid SHALL rise 7 cycles after the last rx handshake edge; with tx_ready=1, bytes SHALL follow every 3 cycles.
REQ-016 frame_cnt SHALL wrap from 0xFFFF to 0.
REQ-017 If tx_ready is already high when tx_valid rises, the transfer SHALL complete in that cycle.

Reset
REQ-018 nRST low SHALL immediately force:
- state=IDLE, idx=k=0, frame_cnt=0;
- all outputs 0, except rx_ready=1 once nRST is released.
REQ-019 Reset mid-frame SHALL discard the partial frame; DUT state is not restored.

Structure
REQ-020 The shared package emu_seq_pkg SHALL hold the state enum, the NUM_STIM/NUM_OUT defaults and the Addr_emu width constant.
REQ-021 The sub-module emu_clkgen (phase counter driving CHI/CLO durations and clk_dut) SHALL be instantiated once.

Verification
REQ-022 The bench SHALL drive the wrapper with the 4-digit counter DUT and cover these scenarios:
- Load: rx 0x05,0x0B -> tx 0x05,0x00,0x00; frame_cnt=1.
- Count: after load, rx 0x00,0x0C -> tx 0x06,0x00,0x00.
- Clear: rx 0x00,0x00 -> tx 0x00,0x00,0x00; exactly one clk_dut pulse per frame.
- Backpressure: tx_ready low for 10 cycles at byte 1 -> tx_data stable; byte order and count unchanged.
- Reset: nRST low during CHI -> clk_dut=0, tx_valid=0, frame_cnt=0 within the same cycle; the next frame completes normally.
- Protocol assertions: load/get/clk_dut never overlap; rx_ready=0 whenever busy outside STIM.

Source files
------------

// File: rtl/emu_seq_pkg.sv
// Shared definitions for the emulation sequencer.
//   state_e      : sequencer FSM states (explicit encodings)
//   NUM_STIM_DEF : default stimulus bytes per frame
//   NUM_OUT_DEF  : default output bytes per frame
//   ADDR_W       : width of the wrapper array index (Addr_emu)
package emu_seq_pkg;

  localparam int unsigned NUM_STIM_DEF = 2;
  localparam int unsigned NUM_OUT_DEF  = 3;
  localparam int unsigned ADDR_W       = 3;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StStim  = 4'd1,
    StWr    = 4'd2,
    StLoad  = 4'd3,
    StChi   = 4'd4,
    StClo   = 4'd5,
    StGet   = 4'd6,
    StRaddr = 4'd7,
    StRcap  = 4'd8,
    StSend  = 4'd9
  } state_e;

endpackage

// File: rtl/emu_sequencer_if.sv
// Host-side byte streams of the emulation sequencer.
//   rx_* : host -> sequencer stimulus bytes (valid/ready)
//   tx_* : sequencer -> host captured output bytes (valid/ready)
// Modports: master = host, slave = sequencer.
interface emu_sequencer_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

endinterface

// File: rtl/emu_clkgen.sv
// Generates one clk_dut pulse per frame and times the high/low phases.
//   clk_emu : emulation clock
//   nRST    : asynchronous active-low reset
//   start   : one-cycle request; clk_dut goes high on the next edge
//   clk_dut : generated DUT clock, straight from a flop
//   hi_done : last cycle of the high phase
//   lo_done : last cycle of the low phase
module emu_clkgen #(
  parameter int unsigned CLK_HIGH = 1,
  parameter int unsigned CLK_LOW  = 1
) (
  input  logic clk_emu,
  input  logic nRST,
  input  logic start,
  output logic clk_dut,
  output logic hi_done,
  output logic lo_done
);

  localparam logic [3:0] HighLast = 4'(CLK_HIGH - 1);
  localparam logic [3:0] LowLast  = 4'(CLK_LOW - 1);

  logic       clk_q, clk_d;
  logic       low_q, low_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    clk_d = clk_q;
    low_d = low_q;
    cnt_d = cnt_q;
    if (start) begin
      clk_d = 1'b1;
      low_d = 1'b0;
      cnt_d = 4'd0;
    end else if (clk_q) begin
      if (cnt_q == HighLast) begin
        clk_d = 1'b0;
        low_d = 1'b1;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (low_q) begin
      if (cnt_q == LowLast) begin
        low_d = 1'b0;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_emu or negedge nRST) begin
    if (!nRST) begin
      clk_q <= 1'b0;
      low_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      clk_q <= clk_d;
      low_q <= low_d;
      cnt_q <= cnt_d;
    end
  end

  assign clk_dut = clk_q;
  assign hi_done = clk_q && (cnt_q == HighLast);
  assign lo_done = low_q && (cnt_q == LowLast);

endmodule

// File: rtl/emu_sequencer.sv
// Frame sequencer between a host byte stream and an emulation wrapper.
// Per frame: collect NUM_STIM stimulus bytes into the wrapper, apply them
// (load_emu), pulse clk_dut once, capture the DUT outputs (get_emu), then
// read NUM_OUT bytes back from the wrapper and stream them to the host.
//   clk_emu   : emulation clock (rising edge)
//   nRST      : asynchronous active-low reset
//   host      : rx (stimulus in) / tx (captured bytes out) valid/ready streams
//   Din_emu   : stimulus byte to the wrapper
//   Addr_emu  : wrapper array index
//   load_emu  : wrapper stimulus-apply strobe
//   get_emu   : wrapper output-capture strobe
//   Dout_emu  : wrapper output byte, valid one cycle after Addr_emu
//   clk_dut   : generated DUT clock
//   busy      : high whenever not idle
//   frame_cnt : completed frames, wraps at 16 bits
module emu_sequencer
  import emu_seq_pkg::*;
#(
  parameter int unsigned NUM_STIM = NUM_STIM_DEF,
  parameter int unsigned NUM_OUT  = NUM_OUT_DEF,
  parameter int unsigned CLK_HIGH = 1,
  parameter int unsigned CLK_LOW  = 1
) (
  input  logic              clk_emu,
  input  logic              nRST,
  emu_sequencer_if.slave    host,
  output logic [7:0]        Din_emu,
  output logic [ADDR_W-1:0] Addr_emu,
  output logic              load_emu,
  output logic              get_emu,
  input  logic [7:0]        Dout_emu,
  output logic              clk_dut,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W-1:0] StimLast = ADDR_W'(NUM_STIM - 1);
  localparam logic [ADDR_W-1:0] OutLast  = ADDR_W'(NUM_OUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [7:0]        din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load_q, load_d;
  logic              get_q, get_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              rx_ready_q, rx_ready_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic clk_start;
  logic hi_done;
  logic lo_done;
  logic rx_fire;

  assign rx_fire = host.rx_valid && rx_ready_q;

  emu_clkgen #(
    .CLK_HIGH(CLK_HIGH),
    .CLK_LOW (CLK_LOW)
  ) u_clkgen (
    .clk_emu(clk_emu),
    .nRST   (nRST),
    .start  (clk_start),
    .clk_dut(clk_dut),
    .hi_done(hi_done),
    .lo_done(lo_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    din_d       = din_q;
    addr_d      = addr_q;
    load_d      = 1'b0;
    get_d       = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    frame_cnt_d = frame_cnt_q;
    clk_start   = 1'b0;

    case (state_q)
      StIdle, StStim: begin
        if (rx_fire) begin
          din_d  = host.rx_data;
          addr_d = idx_q;
          if (idx_q == StimLast) begin
            idx_d   = '0;
            state_d = StWr;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StStim;
          end
        end
      end
      // Din/Addr held so the wrapper commits the last stimulus byte.
      StWr: begin
        state_d = StLoad;
        load_d  = 1'b1;
      end
      StLoad: begin
        state_d   = StChi;
        clk_start = 1'b1;
      end
      StChi: begin
        if (hi_done) state_d = StClo;
      end
      StClo: begin
        if (lo_done) begin
          state_d = StGet;
          get_d   = 1'b1;
          k_d     = '0;
        end
      end
      StGet: begin
        state_d = StRaddr;
        addr_d  = k_q;
      end
      // Wrapper registers Dout_emu from Addr_emu during this cycle.
      StRaddr: begin
        state_d = StRcap;
      end
      StRcap: begin
        tx_data_d  = Dout_emu;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (host.tx_ready) begin
          tx_valid_d = 1'b0;
          if (k_q == OutLast) begin
            k_d         = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = StIdle;
          end else begin
            k_d     = k_q + 1'b1;
            addr_d  = k_q + 1'b1;
            state_d = StRaddr;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered from the next state so both outputs line up with the state.
    rx_ready_d = (state_d == StIdle) || (state_d == StStim);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk_emu or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      k_q         <= '0;
      din_q       <= 8'd0;
      addr_q      <= '0;
      load_q      <= 1'b0;
      get_q       <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      din_q       <= din_d;
      addr_q      <= addr_d;
      load_q      <= load_d;
      get_q       <= get_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign host.rx_ready = rx_ready_q;
  assign host.tx_data  = tx_data_q;
  assign host.tx_valid = tx_valid_q;
  assign Din_emu       = din_q;
  assign Addr_emu      = addr_q;
  assign load_emu      = load_q;
  assign get_emu       = get_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_emu_sequencer.sv
// Bench: sequencer driving a wrapper around a 4-digit BCD counter.
// Counter control byte: bit3=0 clears; else bit0 loads (bit1=1: low byte,
// high cleared; bit1=0: high byte only); else bit2 counts up.
// Output bytes: low BCD byte, high BCD byte, terminal-count flag (9999).
module tb_emu_sequencer;

  logic        clk_emu = 1'b0;
  logic        nRST;
  logic [7:0]  Din_emu;
  logic [2:0]  Addr_emu;
  logic        load_emu;
  logic        get_emu;
  logic [7:0]  Dout_emu;
  logic        clk_dut;
  logic        busy;
  logic [15:0] frame_cnt;

  emu_sequencer_if bus ();

  emu_sequencer #(
    .NUM_STIM(2),
    .NUM_OUT (3),
    .CLK_HIGH(1),
    .CLK_LOW (1)
  ) dut (
    .clk_emu  (clk_emu),
    .nRST     (nRST),
    .host     (bus),
    .Din_emu  (Din_emu),
    .Addr_emu (Addr_emu),
    .load_emu (load_emu),
    .get_emu  (get_emu),
    .Dout_emu (Dout_emu),
    .clk_dut  (clk_dut),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_emu = ~clk_emu;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int pulse_total = 0;
  int model_val = 0;
  bit rand_rdy = 1'b0;
  bit bp_req = 1'b0;
  bit lat_chk = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk_emu) cyc <= cyc + 1;
  always @(posedge clk_dut) pulse_total <= pulse_total + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- wrapper around the counter DUT ----------------
  logic [7:0]  stim_mem [8];
  logic [7:0]  out_mem [8];
  logic [7:0]  c_data = 8'd0;
  logic [7:0]  c_ctrl = 8'd0;
  logic [15:0] c_val = 16'd0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      stim_mem[i] = 8'd0;
      out_mem[i]  = 8'd0;
    end
    Dout_emu = 8'd0;
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        cy;
    r  = v;
    cy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cy) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk_emu) begin
    stim_mem[Addr_emu] <= Din_emu;
    if (get_emu) begin
      out_mem[0] <= c_val[7:0];
      out_mem[1] <= c_val[15:8];
      out_mem[2] <= {7'd0, c_val == 16'h9999};
    end
    Dout_emu <= out_mem[Addr_emu];
  end

  // Apply stimulus mid-LOAD so it is settled before clk_dut rises.
  always @(negedge clk_emu) begin
    if (load_emu) begin
      c_data <= stim_mem[0];
      c_ctrl <= stim_mem[1];
    end
  end

  always @(posedge clk_dut) begin
    if (!c_ctrl[3]) c_val <= 16'd0;
    else if (c_ctrl[0]) begin
      if (c_ctrl[1]) c_val <= {8'h00, c_data};
      else c_val[15:8] <= c_data;
    end else if (c_ctrl[2]) c_val <= bcd_inc(c_val);
  end

  // ---------------- reference model (decimal integer) ----------------
  function automatic int bcd_val(input logic [7:0] d);
    return int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  task automatic issue_frame(input logic [7:0] d, input logic [7:0] c);
    int v;
    v = model_val;
    if (c[3] == 1'b0) v = 0;
    else if (c[0]) begin
      if (c[1]) v = bcd_val(d);
      else v = bcd_val(d) * 100 + v % 100;
    end else if (c[2]) v = (v + 1) % 10000;
    model_val = v;
    exp_q.push_back(8'(((v / 10) % 10) * 16 + v % 10));
    exp_q.push_back(8'(((v / 1000) % 10) * 16 + (v / 100) % 10));
    exp_q.push_back((v == 9999) ? 8'h01 : 8'h00);
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk_emu);
    @(negedge clk_emu);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 300) begin
      @(negedge clk_emu);
      n++;
    end
    chk("rx_accept_in_time", 32'(n < 300), 32'd1);
    @(posedge clk_emu);
    #1;
    hs_cyc       = cyc;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input int gap);
    issue_frame(d, c);
    send_byte(d, gap);
    send_byte(c, gap);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk_emu);
      n++;
    end
    chk("drain_in_time", 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk_emu);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int         byte_idx;
    int         hold;
    bit         waiting;
    bit         pend;
    logic [7:0] held;
    int         snap;
    int         exp_frames;
    int         last_rise;
    byte_idx   = 0;
    hold       = 0;
    waiting    = 1'b0;
    pend       = 1'b0;
    held       = 8'd0;
    snap       = 0;
    exp_frames = 0;
    last_rise  = 0;
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk_emu);
      if (!nRST) begin
        exp_q.delete();
        byte_idx   = 0;
        hold       = 0;
        waiting    = 1'b0;
        pend       = 1'b0;
        exp_frames = 0;
        snap       = pulse_total;
        bus.tx_ready = 1'b1;
        continue;
      end
      chk("strobe_exclusive", 32'($countones({load_emu, get_emu, clk_dut}) <= 1), 32'd1);
      if (load_emu || get_emu || clk_dut || bus.tx_valid)
        chk("rx_ready_low_busy", 32'(bus.rx_ready), 32'd0);
      chk("addr_range", 32'(Addr_emu <= 3'd2), 32'd1);
      if (pend) begin
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames & 16'hFFFF));
        chk("tx_valid_after_frame", 32'(bus.tx_valid), 32'd0);
        chk("clk_dut_pulses", 32'(pulse_total - snap), 32'd1);
        snap = pulse_total;
        pend = 1'b0;
      end
      if (bus.tx_valid) begin
        if (!waiting) begin
          waiting = 1'b1;
          held    = bus.tx_data;
          if (lat_chk) begin
            if (byte_idx == 0) chk("latency", 32'(cyc - hs_cyc), 32'd7);
            else chk("byte_spacing", 32'(cyc - last_rise), 32'd3);
          end
          last_rise = cyc;
          if (bp_req && byte_idx == 1) begin
            hold   = 10;
            bp_req = 1'b0;
          end
        end else begin
          chk("tx_stable", 32'(bus.tx_data), 32'(held));
        end
        if (hold > 0) begin
          bus.tx_ready = 1'b0;
          hold--;
        end else begin
          bus.tx_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (bus.tx_ready) begin
          if (exp_q.size() == 0) chk("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
          else chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          waiting = 1'b0;
          byte_idx++;
          if (byte_idx == 3) begin
            byte_idx = 0;
            exp_frames++;
            pend    = 1'b1;
            lat_chk = 1'b0;
          end
        end
      end else begin
        bus.tx_ready = (hold == 0) && (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    int n;
    logic [7:0] d;
    logic [7:0] c;
    nRST         = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(negedge clk_emu);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_clk_dut", 32'(clk_dut), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_addr", 32'(Addr_emu), 32'd0);
    nRST = 1'b1;
    @(negedge clk_emu);
    chk("rx_ready_after_rst", 32'(bus.rx_ready), 32'd1);

    // Load, with latency and back-to-back spacing checks.
    lat_chk = 1'b1;
    send_frame(8'h05, 8'h0B, 0);
    wait_drain();
    chk("frame_cnt_load", 32'(frame_cnt), 32'd1);

    // Count and clear.
    send_frame(8'h00, 8'h0C, 0);
    wait_drain();
    send_frame(8'h00, 8'h00, 1);
    wait_drain();
    chk("frame_cnt_clear", 32'(frame_cnt), 32'd3);

    // Backpressure on byte 1.
    bp_req = 1'b1;
    send_frame(8'h42, 8'h0B, 0);
    wait_drain();

    // Terminal count and wrap to 0000.
    send_frame(8'h99, 8'h0B, 0);
    send_frame(8'h99, 8'h09, 0);
    send_frame(8'h00, 8'h0C, 2);
    wait_drain();
    chk("frame_cnt_tc", 32'(frame_cnt), 32'd7);

    // Reset in the middle of the clk_dut high phase.
    send_frame(8'h37, 8'h0B, 0);
    n = 0;
    while (!clk_dut && n < 50) begin
      @(negedge clk_emu);
      n++;
    end
    chk("clk_dut_seen", 32'(clk_dut), 32'd1);
    #1 nRST = 1'b0;
    #1;
    chk("midrst_clk_dut", 32'(clk_dut), 32'd0);
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_load_get", 32'({load_emu, get_emu}), 32'd0);
    repeat (2) @(negedge clk_emu);
    nRST = 1'b1;
    @(negedge clk_emu);
    chk("rx_ready_after_midrst", 32'(bus.rx_ready), 32'd1);
    send_frame(8'h00, 8'h0C, 0);
    wait_drain();
    chk("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);

    // Randomised frames with host stalls and random tx backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      case ($urandom_range(0, 4))
        0: c = 8'h0B;
        1: c = 8'h09;
        2: c = 8'h0C;
        3: c = 8'h08;
        default: c = 8'h00;
      endcase
      send_frame(d, c, int'($urandom_range(0, 2)));
    end
    wait_drain();
    chk("frame_cnt_final", 32'(frame_cnt), 32'd31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
